// File: rtl/rtlola_tight_pipeline_monitor.sv
// Event-triggered monitor: one input stream feeds a FIFO and a 4-stage pipeline (output_0..output_3).
// Optional macro QUEUE_BYPASS_EN: an event arriving at an empty queue enters stage 0 directly.
module rtlola_tight_pipeline_monitor #(
  parameter int QUEUE_DEPTH = 4,
  parameter int DATA_W      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] input_0,
  input  logic              new_input_0,
  output logic [DATA_W-1:0] output_0,
  output logic [DATA_W-1:0] output_1,
  output logic [DATA_W-1:0] output_2,
  output logic [DATA_W-1:0] output_3,
  output logic              output_0_aktv,
  output logic              output_1_aktv,
  output logic              output_2_aktv,
  output logic              output_3_aktv,
  output logic              q_push,
  output logic              q_pop,
  output logic              q_push_valid,
  output logic              q_pop_valid,
  output logic              pacing_0,
  output logic              pacing_1,
  output logic              pacing_2,
  output logic              pacing_3
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);

  logic [DATA_W-1:0] mem_q [QUEUE_DEPTH];
  logic [DATA_W-1:0] mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
  logic              s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  logic [DATA_W-1:0] s0_x_q, s0_x_d, s1_x_q, s1_x_d, s2_x_q, s2_x_d;
  logic [DATA_W-1:0] s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
  logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic [3:0]        aktv_q, aktv_d;

  logic              empty, full, push_req, pop_req, push_ok, bypass, wr, rd;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] r0, r1, r2, r3;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == CNT_FULL);
    push_req = new_input_0 & en;
`ifdef QUEUE_BYPASS_EN
    bypass   = empty & push_req;
    pop_req  = en & (~empty | push_req);
`else
    bypass   = 1'b0;
    pop_req  = en & ~empty;
`endif
    push_ok  = push_req & (~full | pop_req);
    wr       = push_ok & ~bypass;
    rd       = pop_req & ~bypass;
    head     = bypass ? input_0 : mem_q[rd_ptr_q];
  end

  // Queue bookkeeping; en is already folded into wr/rd.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr) begin
      mem_d[wr_ptr_q] = input_0;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (rd) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    r0 = s0_x_q + DATA_W'(1);
    r1 = s1_v_q << 1;
    r2 = s2_v_q - s2_x_q;
    r3 = s3_v_q + out3_q;
  end

  // Each stage forwards the raw event value with its own result so back-to-back events stay separate.
  always_comb begin
    s0_vld_d = s0_vld_q;  s0_x_d = s0_x_q;
    s1_vld_d = s1_vld_q;  s1_x_d = s1_x_q;  s1_v_d = s1_v_q;
    s2_vld_d = s2_vld_q;  s2_x_d = s2_x_q;  s2_v_d = s2_v_q;
    s3_vld_d = s3_vld_q;  s3_v_d = s3_v_q;
    out0_d   = out0_q;    out1_d = out1_q;  out2_d = out2_q;  out3_d = out3_q;
    aktv_d   = aktv_q;
    if (en) begin
      s0_vld_d = pop_req;
      if (pop_req) s0_x_d = head;
      s1_vld_d = s0_vld_q;
      s2_vld_d = s1_vld_q;
      s3_vld_d = s2_vld_q;
      aktv_d   = {s3_vld_q, s2_vld_q, s1_vld_q, s0_vld_q};
      if (s0_vld_q) begin
        out0_d = r0;
        s1_x_d = s0_x_q;
        s1_v_d = r0;
      end
      if (s1_vld_q) begin
        out1_d = r1;
        s2_x_d = s1_x_q;
        s2_v_d = r1;
      end
      if (s2_vld_q) begin
        out2_d = r2;
        s3_v_d = r2;
      end
      if (s3_vld_q) out3_d = r3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      s0_vld_q <= 1'b0;  s1_vld_q <= 1'b0;  s2_vld_q <= 1'b0;  s3_vld_q <= 1'b0;
      s0_x_q   <= '0;    s1_x_q   <= '0;    s2_x_q   <= '0;
      s1_v_q   <= '0;    s2_v_q   <= '0;    s3_v_q   <= '0;
      out0_q   <= '0;    out1_q   <= '0;    out2_q   <= '0;    out3_q   <= '0;
      aktv_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      s0_vld_q <= s0_vld_d;  s1_vld_q <= s1_vld_d;  s2_vld_q <= s2_vld_d;  s3_vld_q <= s3_vld_d;
      s0_x_q   <= s0_x_d;    s1_x_q   <= s1_x_d;    s2_x_q   <= s2_x_d;
      s1_v_q   <= s1_v_d;    s2_v_q   <= s2_v_d;    s3_v_q   <= s3_v_d;
      out0_q   <= out0_d;    out1_q   <= out1_d;    out2_q   <= out2_d;    out3_q   <= out3_d;
      aktv_q   <= aktv_d;
    end
  end

  always_comb begin
    output_0      = out0_q;
    output_1      = out1_q;
    output_2      = out2_q;
    output_3      = out3_q;
    output_0_aktv = aktv_q[0] & en;
    output_1_aktv = aktv_q[1] & en;
    output_2_aktv = aktv_q[2] & en;
    output_3_aktv = aktv_q[3] & en;
    pacing_0      = s0_vld_q & en;
    pacing_1      = s1_vld_q & en;
    pacing_2      = s2_vld_q & en;
    pacing_3      = s3_vld_q & en;
    q_push        = push_req;
    q_pop         = pop_req;
    q_push_valid  = push_ok;
    q_pop_valid   = pop_req;
  end

endmodule

// File: tb/tb_rtlola_tight_pipeline_monitor.sv
// Bench for rtlola_tight_pipeline_monitor (default build): event-schedule model plus directed checks.
module tb_rtlola_tight_pipeline_monitor;

  logic        clk = 1'b0;
  logic        rst, en, new_input_0;
  logic [63:0] input_0;
  logic [63:0] output_0, output_1, output_2, output_3;
  logic        output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv;
  logic        q_push, q_pop, q_push_valid, q_pop_valid;
  logic        pacing_0, pacing_1, pacing_2, pacing_3;

  rtlola_tight_pipeline_monitor #(.QUEUE_DEPTH(4), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .output_0(output_0), .output_1(output_1), .output_2(output_2), .output_3(output_3),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
    .output_2_aktv(output_2_aktv), .output_3_aktv(output_3_aktv),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .pacing_0(pacing_0), .pacing_1(pacing_1), .pacing_2(pacing_2), .pacing_3(pacing_3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: every accepted event is stamped with the enabled-edge index n at which it was pushed.
  // Stream k then updates at enabled edge n+k+2 with the value computed straight from the formulas.
  typedef struct packed {
    logic [31:0]      n;
    logic [3:0][63:0] r;
  } ev_t;

  ev_t         evq[$];
  int          ecnt = 0;
  logic [63:0] acc  = 0;
  bit          live = 0;

  always @(posedge clk) begin
    if (rst) begin
      ecnt = 0;
      acc  = 0;
      evq.delete();
      live = 1;
    end else if (en) begin
      ecnt++;
      if (new_input_0) begin
        ev_t e;
        e.n    = 32'(ecnt);
        e.r[0] = input_0 + 64'd1;
        e.r[1] = e.r[0] * 64'd2;
        e.r[2] = e.r[1] - input_0;
        acc    = acc + e.r[2];
        e.r[3] = acc;
        evq.push_back(e);
      end
    end
  end

  logic [63:0] act_out  [4];
  logic        act_aktv [4];
  logic        act_pac  [4];
  always_comb begin
    act_out[0] = output_0;  act_out[1] = output_1;  act_out[2] = output_2;  act_out[3] = output_3;
    act_aktv[0] = output_0_aktv;  act_aktv[1] = output_1_aktv;
    act_aktv[2] = output_2_aktv;  act_aktv[3] = output_3_aktv;
    act_pac[0] = pacing_0;  act_pac[1] = pacing_1;  act_pac[2] = pacing_2;  act_pac[3] = pacing_3;
  end

  always @(negedge clk) begin
    if (live) begin
      logic exp_pop;
      exp_pop = 1'b0;
      foreach (evq[i]) if (en && int'(evq[i].n) == ecnt) exp_pop = 1'b1;
      chk("q_push", {63'd0, q_push}, {63'd0, new_input_0 & en});
      chk("q_push_valid", {63'd0, q_push_valid}, {63'd0, new_input_0 & en});
      chk("q_pop", {63'd0, q_pop}, {63'd0, exp_pop});
      chk("q_pop_valid", {63'd0, q_pop_valid}, {63'd0, exp_pop});
      for (int k = 0; k < 4; k++) begin
        logic [63:0] eo;
        logic        ea, ep;
        eo = 64'd0;  ea = 1'b0;  ep = 1'b0;
        foreach (evq[i]) begin
          if (int'(evq[i].n) + k + 2 <= ecnt) eo = evq[i].r[k];
          if (en && int'(evq[i].n) + k + 2 == ecnt) ea = 1'b1;
          if (en && int'(evq[i].n) + k + 1 == ecnt) ep = 1'b1;
        end
        chk($sformatf("output_%0d", k), act_out[k], eo);
        chk($sformatf("output_%0d_aktv", k), {63'd0, act_aktv[k]}, {63'd0, ea});
        chk($sformatf("pacing_%0d", k), {63'd0, act_pac[k]}, {63'd0, ep});
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [63:0] x);
    new_input_0 = 1'b1;
    input_0     = x;
    step();
    new_input_0 = 1'b0;
  endtask

  logic [63:0] cap0[$], cap2[$], cap3[$];
  int          lat, pulses;

  initial begin
    rst = 1'b1;  en = 1'b1;  new_input_0 = 1'b0;  input_0 = 64'd0;
    step(2);
    rst = 1'b0;
    step(500);
    chk("idle_out3", output_3, 64'd0);
    chk("idle_out0", output_0, 64'd0);

    // single event: aktv_3 five edges after the push edge
    send(64'd1);
    lat = 0;
    while (!output_3_aktv && lat < 20) begin
      step();
      lat++;
    end
    chk("latency_aktv3", 64'(lat), 64'd5);
    chk("x1_out0", output_0, 64'd2);
    chk("x1_out1", output_1, 64'd4);
    chk("x1_out2", output_2, 64'd3);
    chk("x1_out3", output_3, 64'd3);

    step(5);
    send(64'd2);
    step(10);
    chk("x2_out3", output_3, 64'd7);
    send(64'd3);
    step(10);
    chk("x3_out3", output_3, 64'd12);
    chk("x3_out0_hold", output_0, 64'd4);

    // back to back 6,7,8 with accumulator starting at 12
    new_input_0 = 1'b1;
    input_0 = 64'd6;  step();
    input_0 = 64'd7;  step();
    input_0 = 64'd8;  step();
    new_input_0 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (output_0_aktv) cap0.push_back(output_0);
      if (output_2_aktv) cap2.push_back(output_2);
      if (output_3_aktv) begin
        cap3.push_back(output_3);
        pulses++;
      end
      step();
    end
    chk("b2b_pulses3", 64'(pulses), 64'd3);
    chk("b2b_n0", 64'(cap0.size()), 64'd3);
    chk("b2b_n2", 64'(cap2.size()), 64'd3);
    if (cap0.size() == 3 && cap2.size() == 3 && cap3.size() == 3) begin
      chk("b2b_out0_a", cap0[0], 64'd7);
      chk("b2b_out0_b", cap0[1], 64'd8);
      chk("b2b_out0_c", cap0[2], 64'd9);
      chk("b2b_out2_a", cap2[0], 64'd8);
      chk("b2b_out2_b", cap2[1], 64'd9);
      chk("b2b_out2_c", cap2[2], 64'd10);
      chk("b2b_out3_a", cap3[0], 64'd20);
      chk("b2b_out3_b", cap3[1], 64'd29);
      chk("b2b_out3_c", cap3[2], 64'd39);
    end

    // freeze mid-pipeline with a pending input that must be ignored
    send(64'd4);
    step(2);
    en = 1'b0;  new_input_0 = 1'b1;  input_0 = 64'd99;
    step(10);
    chk("frozen_out3", output_3, 64'd39);
    en = 1'b1;  new_input_0 = 1'b0;
    step(10);
    chk("thaw_out0", output_0, 64'd5);
    chk("thaw_out3", output_3, 64'd45);

    // reset with three events in flight
    new_input_0 = 1'b1;
    input_0 = 64'd1;  step();
    input_0 = 64'd2;  step();
    input_0 = 64'd3;  step();
    new_input_0 = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_out0", output_0, 64'd0);
    chk("rst_out3", output_3, 64'd0);
    chk("rst_q_pop", {63'd0, q_pop}, 64'd0);
    step(8);
    chk("rst_drained_out3", output_3, 64'd0);
    send(64'd1);
    step(10);
    chk("post_rst_out3", output_3, 64'd3);

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
